// File: rtl/instr_decode_stage.sv
// instr_decode_stage
//   RV32I decode stage between fetch and execute. Drives the register file
//   read ports combinationally and registers the decoded fields for one cycle
//   so id_* lines up with the register file's rs1/rs2 read data.
//
// Ports
//   clk, reset                 clock, synchronous active-low reset
//   if_valid/if_ready          fetch handshake; if_instr/if_pc carry the word
//   flush                      kills the held instruction and blocks intake
//   ex_ready                   execute consumes id_* this cycle
//   rf_rs1/rs2_en/addr         register file read requests (combinational)
//   id_*                       registered decode results, id_valid qualifies
module instr_decode_stage #(
  parameter int DATA_W       = 32,
  parameter int REG_AW       = 5,
  parameter int SYSTEM_LEGAL = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [DATA_W-1:0] if_instr,
  input  logic [DATA_W-1:0] if_pc,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              rf_rs1_en,
  output logic              rf_rs2_en,
  output logic [REG_AW-1:0] rf_rs1_addr,
  output logic [REG_AW-1:0] rf_rs2_addr,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_pc,
  output logic [6:0]        id_opcode,
  output logic [2:0]        id_funct3,
  output logic              id_funct7b5,
  output logic [REG_AW-1:0] id_rd_addr,
  output logic              id_rd_en,
  output logic [DATA_W-1:0] id_imm,
  output logic              id_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  logic              id_valid_q,    id_valid_d;
  logic [DATA_W-1:0] id_pc_q,       id_pc_d;
  logic [6:0]        id_opcode_q,   id_opcode_d;
  logic [2:0]        id_funct3_q,   id_funct3_d;
  logic              id_funct7b5_q, id_funct7b5_d;
  logic [REG_AW-1:0] id_rd_addr_q,  id_rd_addr_d;
  logic              id_rd_en_q,    id_rd_en_d;
  logic [DATA_W-1:0] id_imm_q,      id_imm_d;
  logic              id_illegal_q,  id_illegal_d;
  // Read-port requests of the held instruction, replayed while stalled.
  logic [REG_AW-1:0] rs1_addr_q,    rs1_addr_d;
  logic [REG_AW-1:0] rs2_addr_q,    rs2_addr_d;
  logic              rs1_en_q,      rs1_en_d;
  logic              rs2_en_q,      rs2_en_d;

  logic [6:0]        opc;
  logic [2:0]        f3;
  logic [6:0]        f7;
  logic              dec_use1, dec_use2, dec_rd, dec_ill;
  logic [DATA_W-1:0] dec_imm;
  logic              acc, hold;

  // Combinational decode of the instruction currently offered by fetch.
  always_comb begin
    opc      = if_instr[6:0];
    f3       = if_instr[14:12];
    f7       = if_instr[31:25];
    dec_use1 = 1'b0;
    dec_use2 = 1'b0;
    dec_rd   = 1'b0;
    dec_ill  = 1'b0;
    dec_imm  = '0;
    case (opc)
      OPC_LUI, OPC_AUIPC: begin
        dec_rd  = 1'b1;
        dec_imm = {if_instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        dec_rd  = 1'b1;
        dec_imm = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                   if_instr[20], if_instr[30:21], 1'b0};
      end
      OPC_JALR: begin
        dec_use1 = 1'b1;
        dec_rd   = 1'b1;
        dec_ill  = (f3 != 3'd0);
        dec_imm  = {{20{if_instr[31]}}, if_instr[31:20]};
      end
      OPC_BRANCH: begin
        dec_use1 = 1'b1;
        dec_use2 = 1'b1;
        dec_ill  = (f3 == 3'd2) || (f3 == 3'd3);
        dec_imm  = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                    if_instr[30:25], if_instr[11:8], 1'b0};
      end
      OPC_LOAD: begin
        dec_use1 = 1'b1;
        dec_rd   = 1'b1;
        dec_ill  = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        dec_imm  = {{20{if_instr[31]}}, if_instr[31:20]};
      end
      OPC_STORE: begin
        dec_use1 = 1'b1;
        dec_use2 = 1'b1;
        dec_ill  = (f3 > 3'd2);
        dec_imm  = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
      end
      OPC_OPIMM: begin
        dec_use1 = 1'b1;
        dec_rd   = 1'b1;
        // Shift-immediates reuse the funct7 field; only SLLI/SRLI/SRAI exist.
        if (f3 == 3'd1)      dec_ill = (f7 != 7'h00);
        else if (f3 == 3'd5) dec_ill = (f7 != 7'h00) && (f7 != 7'h20);
        dec_imm = {{20{if_instr[31]}}, if_instr[31:20]};
      end
      OPC_OP: begin
        dec_use1 = 1'b1;
        dec_use2 = 1'b1;
        dec_rd   = 1'b1;
        if (f7 == 7'h20)      dec_ill = (f3 != 3'd0) && (f3 != 3'd5);
        else if (f7 != 7'h00) dec_ill = 1'b1;
      end
      OPC_FENCE, OPC_SYSTEM: begin
        dec_ill = (SYSTEM_LEGAL == 0);
        dec_imm = {{20{if_instr[31]}}, if_instr[31:20]};
      end
      default: dec_ill = 1'b1;
    endcase
    if (if_instr[1:0] != 2'b11) dec_ill = 1'b1;
    // An illegal word must not touch the register file or produce a value.
    if (dec_ill) begin
      dec_use1 = 1'b0;
      dec_use2 = 1'b0;
      dec_rd   = 1'b0;
      dec_imm  = '0;
    end
  end

  assign if_ready = reset & ~flush & (~id_valid_q | ex_ready);
  assign acc      = if_valid & if_ready;
  assign hold     = id_valid_q & ~ex_ready & ~flush;

  // Read-port drive: new instruction on accept, held request while stalled.
  always_comb begin
    rf_rs1_en   = 1'b0;
    rf_rs2_en   = 1'b0;
    rf_rs1_addr = '0;
    rf_rs2_addr = '0;
    if (reset && !flush) begin
      if (acc) begin
        rf_rs1_en   = dec_use1;
        rf_rs2_en   = dec_use2;
        rf_rs1_addr = if_instr[19:15];
        rf_rs2_addr = if_instr[24:20];
      end else if (hold) begin
        rf_rs1_en   = rs1_en_q;
        rf_rs2_en   = rs2_en_q;
        rf_rs1_addr = rs1_addr_q;
        rf_rs2_addr = rs2_addr_q;
      end
    end
  end

  always_comb begin
    id_valid_d    = id_valid_q;
    id_pc_d       = id_pc_q;
    id_opcode_d   = id_opcode_q;
    id_funct3_d   = id_funct3_q;
    id_funct7b5_d = id_funct7b5_q;
    id_rd_addr_d  = id_rd_addr_q;
    id_rd_en_d    = id_rd_en_q;
    id_imm_d      = id_imm_q;
    id_illegal_d  = id_illegal_q;
    rs1_addr_d    = rs1_addr_q;
    rs2_addr_d    = rs2_addr_q;
    rs1_en_d      = rs1_en_q;
    rs2_en_d      = rs2_en_q;
    if (flush) begin
      id_valid_d = 1'b0;
    end else if (acc) begin
      id_valid_d    = 1'b1;
      id_pc_d       = if_pc;
      id_opcode_d   = opc;
      id_funct3_d   = f3;
      id_funct7b5_d = if_instr[30];
      id_rd_addr_d  = if_instr[11:7];
      id_rd_en_d    = dec_rd && (if_instr[11:7] != '0);
      id_imm_d      = dec_imm;
      id_illegal_d  = dec_ill;
      rs1_addr_d    = if_instr[19:15];
      rs2_addr_d    = if_instr[24:20];
      rs1_en_d      = dec_use1;
      rs2_en_d      = dec_use2;
    end else if (ex_ready) begin
      id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      id_valid_q    <= 1'b0;
      id_pc_q       <= '0;
      id_opcode_q   <= '0;
      id_funct3_q   <= '0;
      id_funct7b5_q <= 1'b0;
      id_rd_addr_q  <= '0;
      id_rd_en_q    <= 1'b0;
      id_imm_q      <= '0;
      id_illegal_q  <= 1'b0;
      rs1_addr_q    <= '0;
      rs2_addr_q    <= '0;
      rs1_en_q      <= 1'b0;
      rs2_en_q      <= 1'b0;
    end else begin
      id_valid_q    <= id_valid_d;
      id_pc_q       <= id_pc_d;
      id_opcode_q   <= id_opcode_d;
      id_funct3_q   <= id_funct3_d;
      id_funct7b5_q <= id_funct7b5_d;
      id_rd_addr_q  <= id_rd_addr_d;
      id_rd_en_q    <= id_rd_en_d;
      id_imm_q      <= id_imm_d;
      id_illegal_q  <= id_illegal_d;
      rs1_addr_q    <= rs1_addr_d;
      rs2_addr_q    <= rs2_addr_d;
      rs1_en_q      <= rs1_en_d;
      rs2_en_q      <= rs2_en_d;
    end
  end

  assign id_valid    = id_valid_q;
  assign id_pc       = id_pc_q;
  assign id_opcode   = id_opcode_q;
  assign id_funct3   = id_funct3_q;
  assign id_funct7b5 = id_funct7b5_q;
  assign id_rd_addr  = id_rd_addr_q;
  assign id_rd_en    = id_rd_en_q;
  assign id_imm      = id_imm_q;
  assign id_illegal  = id_illegal_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage. A small register file sits on the
// read ports so read-data alignment and stall-time writebacks can be observed.
module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        flush;
  logic        ex_ready;
  logic        rf_rs1_en, rf_rs2_en;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic        id_funct7b5;
  logic [4:0]  id_rd_addr;
  logic        id_rd_en;
  logic [31:0] id_imm;
  logic        id_illegal;

  logic [31:0] regs [32];
  logic [31:0] rs1_data, rs2_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int total  = 0;
  int passed = 0;

  localparam logic [31:0] I_ADDI = 32'hFFF08293;
  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SW   = 32'h00312423;
  localparam logic [31:0] I_BEQ  = 32'hFE208EE3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_LUI0 = 32'h12345037;
  localparam logic [31:0] I_LD   = 32'h00013083;
  localparam logic [31:0] I_BOP  = 32'h40001033;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_ECAL = 32'h00000073;

  instr_decode_stage dut (
    .clk(clk), .reset(reset),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc),
    .flush(flush), .ex_ready(ex_ready),
    .rf_rs1_en(rf_rs1_en), .rf_rs2_en(rf_rs2_en),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .id_valid(id_valid), .id_pc(id_pc), .id_opcode(id_opcode),
    .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
    .id_rd_addr(id_rd_addr), .id_rd_en(id_rd_en),
    .id_imm(id_imm), .id_illegal(id_illegal)
  );

  always #5 clk = ~clk;

  // Synchronous-read register file with write-through on a same-cycle write.
  always @(posedge clk) begin
    if (wb_en && wb_addr != 5'd0) regs[wb_addr] <= wb_data;
    if (rf_rs1_en)
      rs1_data <= (wb_en && wb_addr == rf_rs1_addr && wb_addr != 5'd0) ? wb_data : regs[rf_rs1_addr];
    if (rf_rs2_en)
      rs2_data <= (wb_en && wb_addr == rf_rs2_addr && wb_addr != 5'd0) ? wb_data : regs[rf_rs2_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    if_valid = v;
    if_instr = ins;
    if_pc    = pc;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    regs[1] = 32'h11;
    regs[2] = 32'h22;
    rs1_data = '0;
    rs2_data = '0;
    wb_en = 0; wb_addr = '0; wb_data = '0;
    reset = 0; flush = 0; ex_ready = 0;
    drive(0, '0, '0);
    tick();
    tick();

    // Reset state; read ports stay quiet even with a word offered.
    drive(1, I_ADDI, 32'h100);
    #1;
    chk("rst_id_valid", {31'b0, id_valid}, 0);
    chk("rst_id_imm", id_imm, 0);
    chk("rst_if_ready", {31'b0, if_ready}, 0);
    chk("rst_rf_rs1_en", {31'b0, rf_rs1_en}, 0);
    chk("rst_rf_rs1_addr", {27'b0, rf_rs1_addr}, 0);
    reset = 1;
    drive(0, '0, '0);
    tick();

    // T1: ADDI x5,x1,-1
    drive(1, I_ADDI, 32'h100);
    ex_ready = 1;
    #1;
    chk("t1_if_ready", {31'b0, if_ready}, 1);
    chk("t1_rs1_en", {31'b0, rf_rs1_en}, 1);
    chk("t1_rs1_addr", {27'b0, rf_rs1_addr}, 1);
    chk("t1_rs2_en", {31'b0, rf_rs2_en}, 0);
    tick();
    drive(0, '0, '0);
    #1;
    chk("t1_id_valid", {31'b0, id_valid}, 1);
    chk("t1_rd_addr", {27'b0, id_rd_addr}, 5);
    chk("t1_rd_en", {31'b0, id_rd_en}, 1);
    chk("t1_imm", id_imm, 32'hFFFFFFFF);
    chk("t1_pc", id_pc, 32'h100);
    chk("t1_opcode", {25'b0, id_opcode}, 32'h13);
    chk("t1_rs1_data", rs1_data, 32'h11);
    chk("t1_idle_rs1_en", {31'b0, rf_rs1_en}, 0);
    tick();
    chk("t1_drain", {31'b0, id_valid}, 0);

    // T2: ADD, SW, BEQ back-to-back
    drive(1, I_ADD, 32'h200);
    tick();
    chk("t2_add_valid", {31'b0, id_valid}, 1);
    chk("t2_add_imm", id_imm, 0);
    chk("t2_add_rd_en", {31'b0, id_rd_en}, 1);
    drive(1, I_SW, 32'h204);
    #1;
    chk("t2_sw_if_ready", {31'b0, if_ready}, 1);
    chk("t2_sw_rs2_addr", {27'b0, rf_rs2_addr}, 3);
    chk("t2_sw_rs2_en", {31'b0, rf_rs2_en}, 1);
    tick();
    chk("t2_sw_valid", {31'b0, id_valid}, 1);
    chk("t2_sw_imm", id_imm, 8);
    chk("t2_sw_rd_en", {31'b0, id_rd_en}, 0);
    drive(1, I_BEQ, 32'h208);
    tick();
    chk("t2_beq_valid", {31'b0, id_valid}, 1);
    chk("t2_beq_imm", id_imm, 32'hFFFFFFFC);
    chk("t2_beq_rd_en", {31'b0, id_rd_en}, 0);
    chk("t2_beq_pc", id_pc, 32'h208);
    drive(0, '0, '0);
    tick();
    chk("t2_drain", {31'b0, id_valid}, 0);

    // T3: stall with writeback of x1 during the stall
    ex_ready = 0;
    drive(1, I_ADD, 32'h300);
    tick();
    drive(1, I_SUB, 32'h304);
    wb_en = 1; wb_addr = 5'd1; wb_data = 32'h55;
    #1;
    chk("t3_if_ready", {31'b0, if_ready}, 0);
    chk("t3_rs1_addr", {27'b0, rf_rs1_addr}, 1);
    chk("t3_rs2_addr", {27'b0, rf_rs2_addr}, 2);
    chk("t3_rs1_en", {31'b0, rf_rs1_en}, 1);
    chk("t3_rs1_data_old", rs1_data, 32'h11);
    chk("t3_rs2_data", rs2_data, 32'h22);
    tick();
    wb_en = 0;
    chk("t3_pc_frozen", id_pc, 32'h300);
    chk("t3_rs1_data_new", rs1_data, 32'h55);
    chk("t3_rs1_addr_held", {27'b0, rf_rs1_addr}, 1);
    tick();
    chk("t3_valid_held", {31'b0, id_valid}, 1);
    chk("t3_f7b5_frozen", {31'b0, id_funct7b5}, 0);
    tick();
    chk("t3_pc_frozen2", id_pc, 32'h300);
    ex_ready = 1;
    tick();
    chk("t3_sub_pc", id_pc, 32'h304);
    chk("t3_sub_f7b5", {31'b0, id_funct7b5}, 1);
    drive(0, '0, '0);
    tick();

    // T4: rd=x0, illegal encodings, JAL, ECALL
    drive(1, I_LUI0, 32'h400);
    #1;
    chk("t4_lui_rs1_en", {31'b0, rf_rs1_en}, 0);
    chk("t4_lui_rs2_en", {31'b0, rf_rs2_en}, 0);
    tick();
    chk("t4_lui_rd_en", {31'b0, id_rd_en}, 0);
    chk("t4_lui_imm", id_imm, 32'h12345000);
    chk("t4_lui_ill", {31'b0, id_illegal}, 0);
    drive(1, 32'h0, 32'h404);
    #1;
    chk("t4_zero_rs1_en", {31'b0, rf_rs1_en}, 0);
    tick();
    chk("t4_zero_valid", {31'b0, id_valid}, 1);
    chk("t4_zero_ill", {31'b0, id_illegal}, 1);
    chk("t4_zero_imm", id_imm, 0);
    drive(1, I_LD, 32'h408);
    #1;
    chk("t4_ld_rs1_en", {31'b0, rf_rs1_en}, 0);
    tick();
    chk("t4_ld_ill", {31'b0, id_illegal}, 1);
    chk("t4_ld_rd_en", {31'b0, id_rd_en}, 0);
    drive(1, I_BOP, 32'h40C);
    tick();
    chk("t4_badop_ill", {31'b0, id_illegal}, 1);
    drive(1, I_JAL, 32'h410);
    #1;
    chk("t4_jal_rs1_en", {31'b0, rf_rs1_en}, 0);
    tick();
    chk("t4_jal_imm", id_imm, 8);
    chk("t4_jal_rd_en", {31'b0, id_rd_en}, 1);
    chk("t4_jal_ill", {31'b0, id_illegal}, 0);
    drive(1, I_ECAL, 32'h414);
    tick();
    chk("t4_ecall_ill", {31'b0, id_illegal}, 0);
    chk("t4_ecall_rd_en", {31'b0, id_rd_en}, 0);
    drive(0, '0, '0);
    tick();

    // T5: flush while stalled with a word offered
    ex_ready = 0;
    drive(1, I_ADD, 32'h500);
    tick();
    flush = 1;
    drive(1, I_SUB, 32'h504);
    #1;
    chk("t5_if_ready", {31'b0, if_ready}, 0);
    chk("t5_rs1_en", {31'b0, rf_rs1_en}, 0);
    tick();
    flush = 0;
    drive(0, '0, '0);
    #1;
    chk("t5_valid", {31'b0, id_valid}, 0);
    chk("t5_not_taken", (id_pc == 32'h504) ? 32'd1 : 32'd0, 0);
    chk("t5_if_ready_back", {31'b0, if_ready}, 1);

    // T6: reset mid-stream for two cycles
    ex_ready = 1;
    drive(1, I_ADD, 32'h600);
    tick();
    chk("t6_pre_valid", {31'b0, id_valid}, 1);
    reset = 0;
    drive(1, I_SW, 32'h604);
    #1;
    chk("t6_if_ready_rst", {31'b0, if_ready}, 0);
    chk("t6_rs1_en_rst", {31'b0, rf_rs1_en}, 0);
    tick();
    chk("t6_valid", {31'b0, id_valid}, 0);
    chk("t6_pc", id_pc, 0);
    chk("t6_rd_addr", {27'b0, id_rd_addr}, 0);
    chk("t6_rd_en", {31'b0, id_rd_en}, 0);
    tick();
    reset = 1;
    drive(1, I_BEQ, 32'h608);
    #1;
    chk("t6_if_ready_rel", {31'b0, if_ready}, 1);
    tick();
    drive(0, '0, '0);
    chk("t6_acc_valid", {31'b0, id_valid}, 1);
    chk("t6_acc_pc", id_pc, 32'h608);
    chk("t6_acc_imm", id_imm, 32'hFFFFFFFC);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
